// File: rtl/pc_unit_pkg.sv
// Shared constants and types for the fetch-stage program counter.
// Holds the memory map, the ExcCode values and the next-PC select encoding.
// The optional fetch address check (macro PC_FETCH_CHECK_EN) uses fetch_addr_bad.
package pc_unit_pkg;

  // Memory map
  localparam logic [31:0] TEXT_STARTADDR  = 32'h0000_3000;
  localparam logic [31:0] KTEXT_STARTADDR = 32'h0000_4180;
  localparam logic [31:0] IM_SIZE         = 32'h0000_1000;

  // Program counter load values
  localparam logic [31:0] RESET_PC   = TEXT_STARTADDR;
  localparam logic [31:0] HANDLER_PC = KTEXT_STARTADDR;

  // ExcCode values shared with CP0
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // Next-PC source, highest priority first
  typedef enum logic [2:0] {
    NPC_EXC   = 3'd0,
    NPC_ERET  = 3'd1,
    NPC_HOLD  = 3'd2,
    NPC_REDIR = 3'd3,
    NPC_SEQ   = 3'd4
  } npc_sel_e;

  // A fetch address is bad when misaligned or outside the user text window
  function automatic logic fetch_addr_bad(input logic [31:0] addr);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = (addr < TEXT_STARTADDR) || (addr >= (TEXT_STARTADDR + IM_SIZE));
    return misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Request/response bundle between the ID/CP0 side and the fetch PC unit.
// The master drives redirect/exception requests; the slave (pc_unit) returns
// the fetch address, its delay-slot tag and the fetch exception flag.
interface pc_unit_if;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        id_is_jmp;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] PC;
  logic        pc_bd;
  logic        exc_fetch;
  logic [4:0]  exc_code;

  modport master (
    output stall, redir_valid, redir_target, id_is_jmp, exc_req, eret_req, epc,
    input  PC, pc_bd, exc_fetch, exc_code
  );

  modport slave (
    input  stall, redir_valid, redir_target, id_is_jmp, exc_req, eret_req, epc,
    output PC, pc_bd, exc_fetch, exc_code
  );
endinterface

// File: rtl/pc_unit_npc_mux.sv
// Pure combinational next-PC / next-delay-slot-tag priority select.
// Priority: exc_req > eret_req > stall > redir_valid > PC+4.
module pc_unit_npc_mux
  import pc_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        pc_bd,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  input  logic        id_is_jmp,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] npc,
  output logic        npc_bd
);

  npc_sel_e sel;

  // Pick the winning next-PC source
  always_comb begin
    sel = NPC_SEQ;
    if (exc_req) begin
      sel = NPC_EXC;
    end else if (eret_req) begin
      sel = NPC_ERET;
    end else if (stall) begin
      sel = NPC_HOLD;
    end else if (redir_valid) begin
      sel = NPC_REDIR;
    end else begin
      sel = NPC_SEQ;
    end
  end

  // Produce next PC and tag; a sequential advance after a branch lands in its slot
  always_comb begin
    npc    = pc;
    npc_bd = pc_bd;
    case (sel)
      NPC_EXC: begin
        npc    = HANDLER_PC;
        npc_bd = 1'b0;
      end
      NPC_ERET: begin
        npc    = epc;
        npc_bd = 1'b0;
      end
      NPC_HOLD: begin
        npc    = pc;
        npc_bd = pc_bd;
      end
      NPC_REDIR: begin
        npc    = redir_target;
        npc_bd = 1'b0;
      end
      NPC_SEQ: begin
        npc    = pc + 32'd4;
        npc_bd = id_is_jmp;
      end
      default: begin
        npc    = pc;
        npc_bd = pc_bd;
      end
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: registered PC and delay-slot tag feeding IM.
// Optional fetch address check enabled by defining PC_FETCH_CHECK_EN; when
// undefined exc_fetch/exc_code are tied to zero and no compare logic exists.
module pc_unit
  import pc_unit_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  pc_unit_if.slave bus
);

  logic [31:0] pc_r;
  logic        pc_bd_r;
  logic [31:0] npc_s;
  logic        npc_bd_s;

  pc_unit_npc_mux u_npc_mux (
    .pc           (pc_r),
    .pc_bd        (pc_bd_r),
    .stall        (bus.stall),
    .redir_valid  (bus.redir_valid),
    .redir_target (bus.redir_target),
    .id_is_jmp    (bus.id_is_jmp),
    .exc_req      (bus.exc_req),
    .eret_req     (bus.eret_req),
    .epc          (bus.epc),
    .npc          (npc_s),
    .npc_bd       (npc_bd_s)
  );

  // PC and delay-slot tag registers; synchronous reset wins over every request
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r    <= RESET_PC;
      pc_bd_r <= 1'b0;
    end else begin
      pc_r    <= npc_s;
      pc_bd_r <= npc_bd_s;
    end
  end

  assign bus.PC    = pc_r;
  assign bus.pc_bd = pc_bd_r;

`ifdef PC_FETCH_CHECK_EN
  logic fetch_bad_s;

  // Flag the current fetch address; PC keeps advancing and CP0 decides the flush
  always_comb begin
    fetch_bad_s = fetch_addr_bad(pc_r);
  end

  assign bus.exc_fetch = fetch_bad_s;
  assign bus.exc_code  = fetch_bad_s ? EXC_ADEL : EXC_NONE;
`else
  assign bus.exc_fetch = 1'b0;
  assign bus.exc_code  = 5'd0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: a table of directed single-cycle vectors
// plus hand-written sequences for reset priority and the fetch address check.
`timescale 1ns/1ps
module tb_pc_unit;

`ifdef PC_FETCH_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  pc_unit_if bus ();

  pc_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        id_is_jmp;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] exp_pc;
    logic        exp_bd;
  } vec_t;

  vec_t vecs[17];

  // Independent model of the fetch check: text window 0x3000..0x3FFF, word aligned
  function automatic logic exp_fetch(input logic [31:0] a);
    return CHK_EN && ((a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a >= 32'h0000_4000));
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_outputs(input string name, input logic [31:0] exp_pc, input logic exp_bd);
    logic ef;
    ef = exp_fetch(exp_pc);
    check({name, ".PC"}, bus.PC, exp_pc);
    check({name, ".pc_bd"}, {31'd0, bus.pc_bd}, {31'd0, exp_bd});
    check({name, ".exc_fetch"}, {31'd0, bus.exc_fetch}, {31'd0, ef});
    check({name, ".exc_code"}, {27'd0, bus.exc_code}, {27'd0, (ef ? 5'd4 : 5'd0)});
  endtask

  task automatic drive(input logic st, input logic rv, input logic [31:0] rt, input logic jmp,
                       input logic ex, input logic er, input logic [31:0] ep);
    bus.stall        = st;
    bus.redir_valid  = rv;
    bus.redir_target = rt;
    bus.id_is_jmp    = jmp;
    bus.exc_req      = ex;
    bus.eret_req     = er;
    bus.epc          = ep;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          stall rv  target         jmp  exc  eret epc            exp_pc         bd
    vecs[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_3004, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_3008, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_3100, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_3100, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_3104, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_3010, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_3010, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 32'h0000_3200, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_3010, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 32'h0000_3200, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_3010, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_3200, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_3010, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_3014, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_3020, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_3020, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 32'h0000_3300, 1'b1, 1'b1, 1'b1, 32'h0000_3024, 32'h0000_4180, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_3024, 32'h0000_3024, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_3028, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_3028, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0,         32'hFFFF_FFFC, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0000, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 32'h0000_3300, 1'b0, 1'b0, 1'b1, 32'h0000_3000, 32'h0000_3000, 1'b0};

    // Reset for two cycles with idle inputs
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_outputs("reset", 32'h0000_3000, 1'b0);

    // Table-driven vectors: apply, clock once, compare
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].stall, vecs[i].redir_valid, vecs[i].redir_target, vecs[i].id_is_jmp,
            vecs[i].exc_req, vecs[i].eret_req, vecs[i].epc);
      step();
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_bd);
    end

    // Set pc_bd, then reset together with stall+exc+eret must return to 0x3000
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check_outputs("pre_rst", 32'h0000_3004, 1'b1);
    drive(1'b1, 1'b1, 32'h0000_3100, 1'b1, 1'b1, 1'b1, 32'h0000_3024);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_outputs("rst_prio", 32'h0000_3000, 1'b0);

    // Fetch check: misaligned redirect, continue advancing, then low address
    drive(1'b0, 1'b1, 32'h0000_3002, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check_outputs("misalign", 32'h0000_3002, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check_outputs("misalign_adv", 32'h0000_3006, 1'b0);
    drive(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check_outputs("low_addr", 32'h0000_0000, 1'b0);
    drive(1'b0, 1'b1, 32'h0000_3FFC, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check_outputs("top_word", 32'h0000_3FFC, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check_outputs("past_top", 32'h0000_4000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
